// File: rtl/classic_sim_pkg.sv
// Shared types and defaults for the NClassic simulated-keyboard helpers.
// Holds the key-event record, the player state encoding and the default field widths.
package classic_sim_pkg;

  localparam int KEY_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // One scripted keystroke: which key, how long it is pressed, how long it is released.
  typedef struct packed {
    logic [KEY_W_DEF-1:0] keycode;
    logic [CNT_W_DEF-1:0] hold;
    logic [CNT_W_DEF-1:0] gap;
  } key_evt_t;

  typedef enum logic [1:0] {
    KP_IDLE,
    KP_PRESS,
    KP_RELEASE
  } kp_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous first-word-fall-through FIFO of key events.
// The head entry is always visible on head_o while the FIFO is non-empty.
module key_evt_fifo
  import classic_sim_pkg::*;
#(
  parameter type T     = key_evt_t,
  parameter int  DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_in,
  input  T                       push_data_in,
  input  logic                   pop_in,
  output T                       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_pop  = pop_in && !empty_o;
  assign do_push = push_in && (!full_o || do_pop);
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/key_event_player.sv
// Queued simulated-keyboard player: replays {keycode, hold, gap} entries as
// cycle-exact press/release pulses on the core's simkey inputs.
module key_event_player
  import classic_sim_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEPTH    = 8,
  parameter bit WAIT_ACK = 1'b0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_in,
  input  logic [KEY_W-1:0]       push_keycode_in,
  input  logic [CNT_W-1:0]       push_hold_in,
  input  logic [CNT_W-1:0]       push_gap_in,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  input  logic                   key_ack_in,
  output logic [KEY_W-1:0]       keycode_o,
  output logic                   key_pending_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef struct packed {
    logic [KEY_W-1:0] keycode;
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] gap;
  } evt_t;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  kp_state_t        state, state_n;
  logic [CNT_W-1:0] hcnt, hcnt_n;
  logic [CNT_W-1:0] gcnt, gcnt_n;
  logic             ack_seen, ack_seen_n, ack_now;
  logic [KEY_W-1:0] keycode_n;
  logic             pending_n;
  logic             start_key;
  logic             pop;
  evt_t             head;
  evt_t             push_evt;

  assign push_evt = {push_keycode_in, push_hold_in, push_gap_in};

  key_evt_fifo #(
    .T     (evt_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (push_in),
    .push_data_in (push_evt),
    .pop_in       (pop),
    .head_o       (head),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .count_o      (count_o)
  );

  assign busy_o  = (state != KP_IDLE);
  assign ack_now = ack_seen || key_ack_in;
  // The last gap cycle with nothing queued is where the script finishes.
  assign done_o  = (state == KP_RELEASE) && (gcnt == CNT_W'(1)) && empty_o;

  // A new key starts from IDLE, or straight out of the final gap cycle so no IDLE cycle appears.
  assign start_key = !empty_o &&
                     ((state == KP_IDLE) || ((state == KP_RELEASE) && (gcnt == CNT_W'(1))));

  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    gcnt_n     = gcnt;
    ack_seen_n = ack_seen;
    keycode_n  = keycode_o;
    pending_n  = key_pending_o;
    pop        = 1'b0;

    case (state)
      KP_IDLE: begin
      end
      KP_PRESS: begin
        ack_seen_n = ack_now;
        if ((hcnt == CNT_W'(1)) && (!WAIT_ACK || ack_now)) begin
          pending_n  = 1'b0;
          ack_seen_n = 1'b0;
          state_n    = KP_RELEASE;
        end else if (hcnt != CNT_W'(1)) begin
          hcnt_n = hcnt - 1'b1;
        end
      end
      KP_RELEASE: begin
        if (gcnt == CNT_W'(1)) begin
          state_n = KP_IDLE;
        end else begin
          gcnt_n = gcnt - 1'b1;
        end
      end
      default: state_n = KP_IDLE;
    endcase

    // The gap length is captured at pop; it sits untouched until RELEASE counts it down.
    if (start_key) begin
      pop        = 1'b1;
      keycode_n  = head.keycode;
      pending_n  = 1'b1;
      hcnt_n     = at_least_one(head.hold);
      gcnt_n     = at_least_one(head.gap);
      ack_seen_n = 1'b0;
      state_n    = KP_PRESS;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= KP_IDLE;
      hcnt          <= '0;
      gcnt          <= '0;
      ack_seen      <= 1'b0;
      keycode_o     <= '0;
      key_pending_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      state         <= state_n;
      hcnt          <= hcnt_n;
      gcnt          <= gcnt_n;
      ack_seen      <= ack_seen_n;
      keycode_o     <= keycode_n;
      key_pending_o <= pending_n;
      overflow_o    <= overflow_o || (push_in && full_o && !pop);
    end
  end

endmodule

// File: tb/tb_key_event_player.sv
// Self-checking bench for key_event_player: directed scenarios plus a randomized
// script checked against a press-start timeline model.
module tb_key_event_player;

  localparam int KW = 8;
  localparam int CW = 16;
  localparam int DA = 4;
  localparam int DB = 8;
  localparam int NR = 24;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic                a_push = 1'b0;
  logic [KW-1:0]       a_key  = '0;
  logic [CW-1:0]       a_hold = '0;
  logic [CW-1:0]       a_gap  = '0;
  logic                a_ack  = 1'b0;
  logic                a_full, a_empty, a_ovf, a_pend, a_busy, a_done;
  logic [$clog2(DA):0] a_count;
  logic [KW-1:0]       a_kc;

  logic                b_push = 1'b0;
  logic [KW-1:0]       b_key  = '0;
  logic [CW-1:0]       b_hold = '0;
  logic [CW-1:0]       b_gap  = '0;
  logic                b_ack  = 1'b0;
  logic                b_full, b_empty, b_ovf, b_pend, b_busy, b_done;
  logic [$clog2(DB):0] b_count;
  logic [KW-1:0]       b_kc;

  int tests_run    = 0;
  int tests_failed = 0;

  key_event_player #(.KEY_W(KW), .CNT_W(CW), .DEPTH(DA), .WAIT_ACK(1'b0)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .push_in(a_push), .push_keycode_in(a_key),
    .push_hold_in(a_hold), .push_gap_in(a_gap), .full_o(a_full), .empty_o(a_empty),
    .count_o(a_count), .overflow_o(a_ovf), .key_ack_in(a_ack), .keycode_o(a_kc),
    .key_pending_o(a_pend), .busy_o(a_busy), .done_o(a_done)
  );

  key_event_player #(.KEY_W(KW), .CNT_W(CW), .DEPTH(DB), .WAIT_ACK(1'b1)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .push_in(b_push), .push_keycode_in(b_key),
    .push_hold_in(b_hold), .push_gap_in(b_gap), .full_o(b_full), .empty_o(b_empty),
    .count_o(b_count), .overflow_o(b_ovf), .key_ack_in(b_ack), .keycode_o(b_kc),
    .key_pending_o(b_pend), .busy_o(b_busy), .done_o(b_done)
  );

  function automatic int mx1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    a_push = 1'b0; b_push = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic drive_a(input logic en, input logic [KW-1:0] k, input int h, input int g);
    a_push = en; a_key = k; a_hold = CW'(h); a_gap = CW'(g);
  endtask

  task automatic drive_b(input logic en, input logic [KW-1:0] k, input int h, input int g);
    b_push = en; b_key = k; b_hold = CW'(h); b_gap = CW'(g);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({a_full, a_empty, a_count, a_ovf, a_kc, a_pend, a_busy, a_done} !==
        {1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_a: got full=%0b empty=%0b count=%0d ovf=%0b key=%02h pend=%0b busy=%0b done=%0b, want 0 1 0 0 00 0 0 0",
               a_full, a_empty, a_count, a_ovf, a_kc, a_pend, a_busy, a_done);
    end
    tests_run++;
    if ({b_full, b_empty, b_count, b_ovf, b_kc, b_pend, b_busy, b_done} !==
        {1'b0, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_b: got full=%0b empty=%0b count=%0d ovf=%0b key=%02h pend=%0b busy=%0b done=%0b, want 0 1 0 0 00 0 0 0",
               b_full, b_empty, b_count, b_ovf, b_kc, b_pend, b_busy, b_done);
    end
  endtask

  task automatic test_single_key();
    logic ep, ed, eb;
    logic [KW-1:0] ek;
    do_reset();
    drive_a(1'b1, 8'h90, 3, 2);
    tick();
    drive_a(1'b0, 8'h00, 0, 0);
    for (int i = 0; i <= 7; i++) begin
      ep = (i >= 1 && i <= 3);
      ed = (i == 5);
      eb = (i >= 1 && i <= 5);
      ek = (i >= 1) ? 8'h90 : 8'h00;
      tests_run++;
      if ({a_pend, a_done, a_busy, a_kc} !== {ep, ed, eb, ek}) begin
        tests_failed++;
        $display("[TB] FAIL single_key cycle %0d: got pend=%0b done=%0b busy=%0b key=%02h, want pend=%0b done=%0b busy=%0b key=%02h",
                 i, a_pend, a_done, a_busy, a_kc, ep, ed, eb, ek);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic ep, ed;
    logic [KW-1:0] ek;
    logic [KW-1:0] keys [3];
    keys[0] = 8'h41; keys[1] = 8'h09; keys[2] = 8'h4A;
    do_reset();
    drive_a(1'b1, keys[0], 4, 3);
    tick();
    for (int i = 0; i <= 24; i++) begin
      ep = (i >= 1 && i <= 4) || (i >= 8 && i <= 11) || (i >= 15 && i <= 18);
      ed = (i == 21);
      ek = (i < 1) ? 8'h00 : (i < 8) ? keys[0] : (i < 15) ? keys[1] : keys[2];
      tests_run++;
      if ({a_pend, a_done, a_kc} !== {ep, ed, ek}) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back cycle %0d: got pend=%0b done=%0b key=%02h, want pend=%0b done=%0b key=%02h",
                 i, a_pend, a_done, a_kc, ep, ed, ek);
      end
      if (i < 2) drive_a(1'b1, keys[i+1], 4, 3);
      else       drive_a(1'b0, 8'h00, 0, 0);
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [KW-1:0] got[$];
    logic [KW-1:0] want;
    logic prev;
    do_reset();
    drive_a(1'b1, 8'hA0, 40, 1);
    tick();
    drive_a(1'b0, 8'h00, 0, 0);
    tick();
    for (int j = 0; j < 5; j++) begin
      drive_a(1'b1, KW'(8'hB0 + j), 2, 1);
      tick();
      tests_run++;
      if ({a_count, a_full, a_ovf} !== {3'((j < 3) ? j + 1 : 4), (j >= 3), (j == 4)}) begin
        tests_failed++;
        $display("[TB] FAIL overflow_fill push %0d: got count=%0d full=%0b ovf=%0b, want count=%0d full=%0b ovf=%0b",
                 j, a_count, a_full, a_ovf, (j < 3) ? j + 1 : 4, (j >= 3), (j == 4));
      end
    end
    drive_a(1'b0, 8'h00, 0, 0);
    prev = a_pend;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (a_pend && !prev) got.push_back(a_kc);
      prev = a_pend;
    end
    tests_run++;
    if (got.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL overflow_play_count: got %0d presses, want 4", got.size());
    end
    for (int j = 0; j < 4; j++) begin
      want = KW'(8'hB0 + j);
      tests_run++;
      if (j >= got.size() || got[j] !== want) begin
        tests_failed++;
        $display("[TB] FAIL overflow_order key %0d: got %02h, want %02h",
                 j, (j < got.size()) ? got[j] : 8'h00, want);
      end
    end
    tests_run++;
    if ({a_ovf, a_empty, a_busy} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL overflow_end: got ovf=%0b empty=%0b busy=%0b, want 1 1 0", a_ovf, a_empty, a_busy);
    end
  endtask

  task automatic test_wait_ack();
    logic ep, ed;
    logic [KW-1:0] ek;
    do_reset();
    drive_b(1'b1, 8'h5C, 2, 3);
    tick();
    drive_b(1'b0, 8'h00, 0, 0);
    for (int i = 0; i <= 16; i++) begin
      ep = (i >= 1 && i <= 11);
      ed = (i == 14);
      ek = (i >= 1) ? 8'h5C : 8'h00;
      tests_run++;
      if ({b_pend, b_done, b_kc} !== {ep, ed, ek}) begin
        tests_failed++;
        $display("[TB] FAIL wait_ack_late cycle %0d: got pend=%0b done=%0b key=%02h, want pend=%0b done=%0b key=%02h",
                 i, b_pend, b_done, b_kc, ep, ed, ek);
      end
      b_ack = (i == 11);
      tick();
    end
    // An ack seen early in the press is remembered until the hold count runs out.
    do_reset();
    drive_b(1'b1, 8'h33, 5, 1);
    tick();
    drive_b(1'b0, 8'h00, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      ep = (i >= 1 && i <= 5);
      ed = (i == 6);
      tests_run++;
      if ({b_pend, b_done} !== {ep, ed}) begin
        tests_failed++;
        $display("[TB] FAIL wait_ack_early cycle %0d: got pend=%0b done=%0b, want pend=%0b done=%0b",
                 i, b_pend, b_done, ep, ed);
      end
      b_ack = (i == 1);
      tick();
    end
  endtask

  task automatic test_zero_hold_gap();
    logic ep, ed;
    logic [KW-1:0] ek;
    do_reset();
    drive_a(1'b1, 8'h11, 0, 0);
    tick();
    for (int i = 0; i <= 6; i++) begin
      ep = (i == 1) || (i == 3);
      ed = (i == 4);
      ek = (i < 1) ? 8'h00 : (i < 3) ? 8'h11 : 8'h22;
      tests_run++;
      if ({a_pend, a_done, a_kc} !== {ep, ed, ek}) begin
        tests_failed++;
        $display("[TB] FAIL zero_hold_gap cycle %0d: got pend=%0b done=%0b key=%02h, want pend=%0b done=%0b key=%02h",
                 i, a_pend, a_done, a_kc, ep, ed, ek);
      end
      if (i == 0) drive_a(1'b1, 8'h22, 0, 0);
      else        drive_a(1'b0, 8'h00, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset_mid_press();
    logic seen;
    logic ep, ed;
    do_reset();
    drive_a(1'b1, 8'h77, 20, 1);
    tick();
    for (int j = 0; j < 3; j++) begin
      drive_a(1'b1, KW'(8'h78 + j), 2, 1);
      tick();
    end
    drive_a(1'b0, 8'h00, 0, 0);
    tests_run++;
    if ({a_pend, a_count} !== {1'b1, 3'd3}) begin
      tests_failed++;
      $display("[TB] FAIL mid_press_setup: got pend=%0b count=%0d, want pend=1 count=3", a_pend, a_count);
    end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tests_run++;
    if ({a_pend, a_empty, a_count, a_busy, a_done, a_ovf, a_kc} !==
        {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("[TB] FAIL mid_press_reset: got pend=%0b empty=%0b count=%0d busy=%0b done=%0b ovf=%0b key=%02h, want 0 1 0 0 0 0 00",
               a_pend, a_empty, a_count, a_busy, a_done, a_ovf, a_kc);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | a_done | a_pend;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_press_quiet: got activity=%0b, want 0", seen);
    end
    drive_a(1'b1, 8'h55, 2, 1);
    tick();
    drive_a(1'b0, 8'h00, 0, 0);
    for (int i = 0; i <= 5; i++) begin
      ep = (i >= 1 && i <= 2);
      ed = (i == 3);
      tests_run++;
      if ({a_pend, a_done} !== {ep, ed} || (i >= 1 && a_kc !== 8'h55)) begin
        tests_failed++;
        $display("[TB] FAIL mid_press_replay cycle %0d: got pend=%0b done=%0b key=%02h, want pend=%0b done=%0b key=55",
                 i, a_pend, a_done, a_kc, ep, ed);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int p [NR];
    int hh [NR];
    int gg [NR];
    logic [KW-1:0] kk [NR];
    bit acc [NR];
    int s [NR];
    logic ep [256];
    logic ed [256];
    logic [KW-1:0] ek [256];
    int occ, last, dec, nxt, horizon, ptr;
    bit popnow, any_drop;

    do_reset();
    p[0] = int'($urandom_range(3, 1));
    for (int i = 1; i < NR; i++) p[i] = p[i-1] + int'($urandom_range(6, 1));
    for (int i = 0; i < NR; i++) begin
      hh[i] = int'($urandom_range(4, 0));
      gg[i] = int'($urandom_range(4, 0));
      kk[i] = KW'($urandom_range(255, 1));
    end

    // Each press starts right after the previous gap if already queued, else one edge after its push.
    last = -1;
    any_drop = 1'b0;
    for (int i = 0; i < NR; i++) begin
      occ = 0;
      popnow = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (acc[j]) begin
          if (s[j] >= p[i]) occ++;
          if (s[j] == p[i]) popnow = 1'b1;
        end
      end
      acc[i] = (occ < DA) || popnow;
      s[i] = 0;
      if (!acc[i]) begin
        any_drop = 1'b1;
      end else begin
        if (last < 0) begin
          s[i] = p[i] + 1;
        end else begin
          dec = s[last] + mx1(hh[last]) + mx1(gg[last]) - 1;
          s[i] = (p[i] <= dec) ? dec + 1 : ((p[i] + 1 > dec + 2) ? p[i] + 1 : dec + 2);
        end
        last = i;
      end
    end

    horizon = p[NR-1] + 60;
    for (int t = 0; t < 256; t++) begin
      ep[t] = 1'b0; ed[t] = 1'b0; ek[t] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        for (int t = s[i]; t < s[i] + mx1(hh[i]); t++) ep[t] = 1'b1;
        for (int t = s[i]; t < 256; t++) ek[t] = kk[i];
        dec = s[i] + mx1(hh[i]) + mx1(gg[i]) - 1;
        nxt = -1;
        for (int j = NR - 1; j > i; j--) if (acc[j]) nxt = j;
        if (nxt < 0 || p[nxt] > dec) ed[dec] = 1'b1;
      end
    end

    ptr = 0;
    for (int t = 0; t <= horizon; t++) begin
      tests_run++;
      if ({a_pend, a_done, a_kc} !== {ep[t], ed[t], ek[t]}) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: got pend=%0b done=%0b key=%02h, want pend=%0b done=%0b key=%02h",
                 t, a_pend, a_done, a_kc, ep[t], ed[t], ek[t]);
      end
      if (ptr < NR && p[ptr] == t + 1) begin
        drive_a(1'b1, kk[ptr], hh[ptr], gg[ptr]);
        ptr++;
      end else begin
        drive_a(1'b0, 8'h00, 0, 0);
      end
      tick();
    end
    tests_run++;
    if ({a_ovf, a_empty, a_busy} !== {any_drop, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL random_end: got ovf=%0b empty=%0b busy=%0b, want ovf=%0b empty=1 busy=0",
               a_ovf, a_empty, a_busy, any_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_back_to_back();
    test_overflow();
    test_wait_ack();
    test_zero_hold_gap();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
